// File: rtl/starflux_pkg.sv
// Shared types and screen constants for the starflux game blocks.
// Used by the collision stage and the enemy mover.
package starflux_pkg;

  typedef enum logic [1:0] {
    RELOAD = 2'd0,
    ARMED  = 2'd1,
    WON    = 2'd2
  } hd_state_e;

  localparam logic [7:0] SCREEN_X_MAX = 8'd120;
  localparam logic [7:0] ENEMY_Y_DEF  = 8'd100;
  localparam logic [7:0] ENEMY_W_DEF  = 8'd8;
  localparam logic [7:0] ENEMY_H_DEF  = 8'd4;

  typedef struct packed {
    logic [7:0] ex;
    logic [7:0] bx;
    logic [7:0] by;
  } hd_in_t;

  function automatic logic [1:0] sat3(
    input logic [7:0] s
  );
    return (s > 8'd3) ? 2'd3 : s[1:0];
  endfunction

endpackage

// File: rtl/bbox_overlap.sv
// Point-in-box test on 8-bit coordinates.
// Bounds are formed in 9 bits so boxes near 255 never wrap.
module bbox_overlap (
  input  logic [7:0] box_x_i,
  input  logic [7:0] box_y_i,
  input  logic [7:0] box_w_i,
  input  logic [7:0] box_h_i,
  input  logic [7:0] pt_x_i,
  input  logic [7:0] pt_y_i,
  output logic       hit_o
);

  logic [8:0] x_lo;
  logic [8:0] y_lo;
  logic [8:0] x_hi;
  logic [8:0] y_hi;
  logic [8:0] px;
  logic [8:0] py;
  logic       in_x;
  logic       in_y;

  assign x_lo = {1'b0, box_x_i};
  assign y_lo = {1'b0, box_y_i};
  assign px   = {1'b0, pt_x_i};
  assign py   = {1'b0, pt_y_i};
  assign x_hi = x_lo + {1'b0, box_w_i} - 9'd1;
  assign y_hi = y_lo + {1'b0, box_h_i} - 9'd1;

  // A zero-sized box matches nothing.
  assign in_x = (box_w_i != 8'd0)
              && (px >= x_lo)
              && (px <= x_hi);
  assign in_y = (box_h_i != 8'd0)
              && (py >= y_lo)
              && (py <= y_hi);

  assign hit_o = in_x && in_y;

endmodule

// File: rtl/hit_detector.sv
// Bullet/enemy collision, miss detection, reload timing and score.
// Detection runs on registered copies of the positions.
module hit_detector
  import starflux_pkg::*;
#(
  parameter logic [7:0]  ENEMY_Y       = ENEMY_Y_DEF,
  parameter logic [7:0]  ENEMY_W       = ENEMY_W_DEF,
  parameter logic [7:0]  ENEMY_H       = ENEMY_H_DEF,
  parameter logic [7:0]  BULLET_Y_MAX  = 8'd119,
  parameter logic [27:0] RELOAD_CYCLES = 28'd50_000_000,
  parameter logic [7:0]  WIN_HITS      = 8'd8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_game,
  input  logic [7:0] x_val_enemy,
  input  logic [7:0] x_val_bullet,
  input  logic [7:0] y_val_bullet,
  output logic [1:0] hitCount,
  output logic [7:0] score,
  output logic       hit_pulse,
  output logic       bullet_reset,
  output logic       game_won
);

  hd_in_t     in_q;
  hd_state_e  state_q;
  hd_state_e  state_d;
  logic [27:0] cnt_q;
  logic [27:0] cnt_d;
  logic [7:0] score_q;
  logic [7:0] score_d;
  logic [7:0] score_inc;
  logic [1:0] hitcnt_q;
  logic [1:0] hitcnt_d;
  logic       pulse_q;
  logic       pulse_d;
  logic       overlap;
  logic       miss;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_q <= '0;
    end else begin
      in_q <= {x_val_enemy, x_val_bullet, y_val_bullet};
    end
  end

  bbox_overlap u_bbox (
    .box_x_i (in_q.ex),
    .box_y_i (ENEMY_Y),
    .box_w_i (ENEMY_W),
    .box_h_i (ENEMY_H),
    .pt_x_i  (in_q.bx),
    .pt_y_i  (in_q.by),
    .hit_o   (overlap)
  );

  assign miss = (in_q.by > BULLET_Y_MAX);

  assign score_inc = (score_q == 8'hFF) ? score_q
                                        : score_q + 8'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= RELOAD;
      cnt_q    <= '0;
      score_q  <= '0;
      hitcnt_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      score_q  <= score_d;
      hitcnt_q <= hitcnt_d;
      pulse_q  <= pulse_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    score_d  = score_q;
    hitcnt_d = hitcnt_q;
    pulse_d  = 1'b0;
    if (start_game) begin
      state_d  = RELOAD;
      cnt_d    = '0;
      score_d  = '0;
      hitcnt_d = '0;
    end else begin
      unique case (state_q)
        RELOAD: begin
          if (cnt_q == RELOAD_CYCLES - 28'd1) begin
            cnt_d   = '0;
            state_d = ARMED;
          end else begin
            cnt_d = cnt_q + 28'd1;
          end
        end
        ARMED: begin
          // Overlap takes priority over an off-screen miss.
          if (overlap) begin
            pulse_d  = 1'b1;
            score_d  = score_inc;
            hitcnt_d = sat3(score_inc);
            cnt_d    = '0;
            state_d  = (score_inc == WIN_HITS) ? WON
                                               : RELOAD;
          end else if (miss) begin
            cnt_d   = '0;
            state_d = RELOAD;
          end
        end
        WON: begin
          state_d = WON;
        end
        default: begin
          cnt_d   = '0;
          state_d = RELOAD;
        end
      endcase
    end
  end

  always_comb begin
    bullet_reset = (state_q != ARMED);
    game_won     = (state_q == WON);
  end

  assign score     = score_q;
  assign hitCount  = hitcnt_q;
  assign hit_pulse = pulse_q;

endmodule

// File: tb/tb_hit_detector.sv
// Directed scenarios plus randomized play against a behavioural model.
module tb_hit_detector;

  localparam int RC  = 4;
  localparam int WIN = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_game;
  logic [7:0] xe;
  logic [7:0] xb;
  logic [7:0] yb;
  logic [1:0] hitCount;
  logic [7:0] score;
  logic       hit_pulse;
  logic       bullet_reset;
  logic       game_won;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  hit_detector #(
    .RELOAD_CYCLES (28'd4),
    .WIN_HITS      (8'd3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start_game   (start_game),
    .x_val_enemy  (xe),
    .x_val_bullet (xb),
    .y_val_bullet (yb),
    .hitCount     (hitCount),
    .score        (score),
    .hit_pulse    (hit_pulse),
    .bullet_reset (bullet_reset),
    .game_won     (game_won)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: reload cycles remaining, won flag, score, and
  // the positions as seen one cycle late by the detector.
  int m_rl;
  int m_score;
  bit m_won;
  bit m_pulse;
  int m_ex;
  int m_bx;
  int m_by;

  always @(posedge clock or negedge reset) begin : model
    int rl;
    int sc;
    bit wn;
    bit pl;
    bit ov;
    if (!reset) begin
      m_rl    <= RC;
      m_score <= 0;
      m_won   <= 1'b0;
      m_pulse <= 1'b0;
      m_ex    <= 0;
      m_bx    <= 0;
      m_by    <= 0;
    end else begin
      rl = m_rl;
      sc = m_score;
      wn = m_won;
      pl = 1'b0;
      ov = (m_bx >= m_ex) && (m_bx <= m_ex + 7)
        && (m_by >= 100) && (m_by <= 103);
      if (start_game) begin
        rl = RC;
        sc = 0;
        wn = 1'b0;
      end else if (wn) begin
        rl = rl;
      end else if (rl > 0) begin
        rl = rl - 1;
      end else if (ov) begin
        pl = 1'b1;
        sc = (sc < 255) ? sc + 1 : 255;
        if (sc == WIN) wn = 1'b1;
        else rl = RC;
      end else if (m_by > 119) begin
        rl = RC;
      end
      m_rl    <= rl;
      m_score <= sc;
      m_won   <= wn;
      m_pulse <= pl;
      m_ex    <= int'(xe);
      m_bx    <= int'(xb);
      m_by    <= int'(yb);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("m_hit_pulse", hit_pulse, m_pulse);
      chk("m_score", score, m_score);
      chk("m_hitCount", hitCount,
          (m_score > 3) ? 3 : m_score);
      chk("m_bullet_reset", bullet_reset,
          (m_won || m_rl > 0) ? 1 : 0);
      chk("m_game_won", game_won, m_won);
    end
  end

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_armed();
    int n;
    n = 0;
    while (bullet_reset && n < 50) begin
      cyc();
      n++;
    end
    chk("armed_timeout", bullet_reset, 0);
  endtask

  task automatic reload_len(input string name);
    int n;
    n = 0;
    while (bullet_reset && n < 20) begin
      cyc();
      n++;
    end
    chk(name, n, RC);
  endtask

  initial begin
    reset      = 1'b0;
    start_game = 1'b0;
    xe = 8'd0;
    xb = 8'd0;
    yb = 8'd0;
    repeat (2) cyc();
    chk_en = 1'b1;
    chk("rst_bullet_reset", bullet_reset, 1);
    chk("rst_score", score, 0);
    chk("rst_hitCount", hitCount, 0);
    chk("rst_hit_pulse", hit_pulse, 0);
    chk("rst_game_won", game_won, 0);

    reset = 1'b1;
    reload_len("reload_len_first");
    chk("armed_score", score, 0);

    xe = 8'd40; xb = 8'd47; yb = 8'd101;
    cyc();
    chk("hit_early", hit_pulse, 0);
    cyc();
    chk("hit_pulse", hit_pulse, 1);
    chk("hit_score", score, 1);
    chk("hit_count", hitCount, 1);
    chk("hit_reload", bullet_reset, 1);
    repeat (3) begin
      cyc();
      chk("no_rehit", hit_pulse, 0);
      chk("rehit_reload", bullet_reset, 1);
    end
    yb = 8'd0;
    cyc();
    chk("reload_done", bullet_reset, 0);
    chk("score_kept", score, 1);

    xe = 8'd40; xb = 8'd48; yb = 8'd101;
    repeat (3) cyc();
    chk("right_edge_nohit", score, 1);
    chk("right_edge_armed", bullet_reset, 0);
    yb = 8'd120;
    cyc();
    chk("miss_latency", bullet_reset, 0);
    cyc();
    chk("miss_reload", bullet_reset, 1);
    chk("miss_score", score, 1);
    yb = 8'd0;
    wait_armed();

    xe = 8'd250; xb = 8'd2; yb = 8'd100;
    repeat (3) cyc();
    chk("wrap_nohit", score, 1);
    chk("wrap_armed", bullet_reset, 0);
    xb = 8'd255; yb = 8'd103;
    cyc(); cyc();
    chk("corner_pulse", hit_pulse, 1);
    chk("corner_score", score, 2);
    chk("corner_count", hitCount, 2);
    yb = 8'd0;
    wait_armed();

    xe = 8'd40; xb = 8'd40; yb = 8'd100;
    cyc(); cyc();
    chk("win_pulse", hit_pulse, 1);
    chk("win_score", score, 3);
    chk("win_count", hitCount, 3);
    chk("win_flag", game_won, 1);
    chk("win_reload", bullet_reset, 1);
    repeat (8) cyc();
    chk("won_frozen", score, 3);
    chk("won_held", game_won, 1);

    yb = 8'd0;
    start_game = 1'b1;
    cyc();
    start_game = 1'b0;
    chk("sg_score", score, 0);
    chk("sg_count", hitCount, 0);
    chk("sg_won", game_won, 0);
    chk("sg_reload", bullet_reset, 1);
    reload_len("reload_len_sg");

    xe = 8'd10; xb = 8'd12; yb = 8'd102;
    cyc(); cyc();
    chk("pre_rst_score", score, 1);
    yb = 8'd0;
    cyc(); cyc();
    #2;
    reset = 1'b0;
    #1;
    chk("async_score", score, 0);
    chk("async_count", hitCount, 0);
    chk("async_reload", bullet_reset, 1);
    cyc();
    reset = 1'b1;
    reload_len("reload_len_rst");

    repeat (4000) begin
      reset = ($urandom_range(0, 599) != 0);
      start_game = ($urandom_range(0, 59) == 0);
      xe = 8'($urandom);
      case ($urandom_range(0, 3))
        0: xb = 8'($urandom);
        default: xb = xe + 8'($urandom_range(0, 9)) - 8'd1;
      endcase
      case ($urandom_range(0, 3))
        0: yb = 8'($urandom);
        1: yb = 8'($urandom_range(116, 123));
        default: yb = 8'($urandom_range(97, 106));
      endcase
      cyc();
    end
    reset = 1'b1;
    start_game = 1'b0;
    cyc();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/hit_detector.md
Name: hit_detector

Overview:
- Collision/score stage between the bullet generator (shoot) and the enemy mover.
- Consumes enemy x position and bullet x/y, detects bullet-enemy overlap and off-screen misses, and requests a bullet reload.
- Keeps a hit score and drives the 2-bit hitCount that sets enemy speed.
- Asserts game_won after WIN_HITS hits.

Parameters:
- ENEMY_Y, 8'd100, top row of the enemy sprite.
- ENEMY_W, 8'd8, enemy sprite width in pixels.
- ENEMY_H, 8'd4, enemy sprite height in pixels.
- BULLET_Y_MAX, 8'd119, last on-screen bullet row; beyond it counts as a miss.
- RELOAD_CYCLES, 28'd50_000_000, cycles bullet_reset is held; must exceed one slow tick of shoot.
- WIN_HITS, 8'd8, score at which the game is won (1..255).

Ports:
- clock, in, 1, 50 MHz board clock.
- reset, in, 1, asynchronous active-low reset.
- start_game, in, 1, synchronous level; while high, the game is cleared.
- x_val_enemy, in, 8, enemy x position.
- x_val_bullet, in, 8, bullet x position.
- y_val_bullet, in, 8, bullet y position.
- hitCount, out, 2, saturating min(score,3); feeds the enemy speed select.
- score, out, 8, number of hits this game.
- hit_pulse, out, 1, one-cycle strobe per registered hit.
- bullet_reset, out, 1, reload request to shoot (active-high level).
- game_won, out, 1, high in WON.

Behaviour:
- Reset (reset=0, async): state=RELOAD, counter=0, score=0, hitCount=0, hit_pulse=0, bullet_reset=1, game_won=0. Input registers clear to 0.
- Input stage: x_val_enemy, x_val_bullet and y_val_bullet are registered each cycle, so detection sees 1-cycle-old values. Latency from input change to hit_pulse/state change is 2 cycles.
- Overlap (on registered values, 9-bit arithmetic, no wrap):
  - bx >= ex and bx <= ex+ENEMY_W-1, and
  - by >= ENEMY_Y and by <= ENEMY_Y+ENEMY_H-1.
- Miss: by > BULLET_Y_MAX.
- States:
  - RELOAD: bullet_reset=1, counter increments. When counter==RELOAD_CYCLES-1: counter=0, go to ARMED.
  - ARMED: bullet_reset=0.
    - On overlap: hit_pulse=1 for 1 cycle, score+=1, hitCount=min(score_new,3). If score_new==WIN_HITS go to WON, else go to RELOAD.
    - Else on miss: go to RELOAD, score unchanged.
    - Overlap and miss together: overlap wins. This cannot occur while ENEMY_Y+ENEMY_H-1 <= BULLET_Y_MAX.
  - WON: game_won=1, bullet_reset=1, score frozen. Leaves only via start_game or reset.
- start_game=1 in any state (checked first each cycle): score=0, hitCount=0, game_won=0, counter=0, state=RELOAD. Held high, the block stays in RELOAD with the counter held at 0.
- Overlap/miss are ignored outside ARMED: at most one hit per bullet, no double counts while reloading.
- score saturates at 255, unreachable when WIN_HITS<=255.
- hitCount is registered and changes in the same cycle as score.
- Reset mid-RELOAD/ARMED/WON returns to reset values immediately, independent of clock.

Decomposition:
- Shared package (starflux_pkg): state encoding (RELOAD=2'd0, ARMED=2'd1, WON=2'd2), the screen constant SCREEN_X_MAX=8'd120 shared with the enemy block, and the default ENEMY_Y/ENEMY_W/ENEMY_H.
- One sub-module, bbox_overlap: combinational 9-bit range compare, reusable for future enemy-ship collision.
- Counter and FSM stay in hit_detector.

Test Plan (RELOAD_CYCLES=4, WIN_HITS=3 for sim):
- Reset release, all inputs 0 -> bullet_reset=1 for exactly 4 cycles, then state ARMED, bullet_reset=0, score=0, hitCount=0.
- ARMED, ex=40, bx=47, by=101 -> hit_pulse high exactly 1 cycle, 2 cycles after stimulus. score=1, hitCount=1, bullet_reset=1 for 4 cycles. Holding the same inputs during RELOAD produces no further pulse.
- ARMED, ex=40, bx=48, by=101 (one pixel right of box) -> no hit. Then by=120 -> RELOAD entered, score unchanged.
- Edge/wrap: ex=250, bx=2, by=100 -> no hit, since 9-bit ex+7=257 never matches bx=2.
- Three hits in sequence -> score=3, hitCount=3, game_won=1, bullet_reset stays 1. A further overlap is ignored. Then start_game pulse -> score=0, game_won=0, RELOAD then ARMED.
- reset asserted mid-RELOAD with counter=2 -> outputs return to reset values within the same cycle. Counter restarts from 0 after release.
